temporizador_bcd: RTL and testbench



---
 rtl/temporizador_bcd.sv | 132 +++++++++++++
 tb/tb_temporizador_bcd.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/temporizador_bcd.sv
// temporizador_bcd: BCD hh:mm:ss up/down timer with
// saturating loads and stop-or-wrap terminal handling.
module temporizador_bcd #(
  parameter int HORA_MAX = 23,
  parameter bit WRAP     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cargar,
  input  logic       habilitar,
  input  logic       modo,
  input  logic [7:0] hora_in,
  input  logic [7:0] minuto_in,
  input  logic [7:0] segundo_in,
  output logic [7:0] hora_out,
  output logic [7:0] minuto_out,
  output logic [7:0] segundo_out,
  output logic       fin,
  output logic       activo
);

  localparam logic [7:0] H_MAX =
    {4'(HORA_MAX / 10), 4'(HORA_MAX % 10)};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  function automatic logic [7:0] validar(
    input logic [7:0] v,
    input logic [7:0] mx
  );
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > mx)
      return mx;
    return v;
  endfunction

  // {wrap, value}: one digit-wise BCD step of a field.
  function automatic logic [8:0] paso(
    input logic [7:0] v,
    input logic [7:0] mx,
    input logic       up
  );
    logic [8:0] r;
    if (up) begin
      if (v == mx)
        r = {1'b1, 8'h00};
      else if (v[3:0] == 4'd9)
        r = {1'b0, v[7:4] + 4'd1, 4'd0};
      else
        r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)
        r = {1'b1, mx};
      else if (v[3:0] == 4'd0)
        r = {1'b0, v[7:4] - 4'd1, 4'd9};
      else
        r = {1'b0, v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  logic [8:0]  s_st, m_st, h_st;
  logic [23:0] sig, term;
  logic        vuelta;

  always_comb begin
    s_st = paso(segundo_out, 8'h59, modo);
    m_st = s_st[8] ? paso(minuto_out, 8'h59, modo)
                   : {1'b0, minuto_out};
    h_st = m_st[8] ? paso(hora_out, H_MAX, modo)
                   : {1'b0, hora_out};
  end

  // Hours only wrap when every field wraps: count sat at terminal.
  assign vuelta = h_st[8];
  assign sig    = {h_st[7:0], m_st[7:0], s_st[7:0]};
  assign term   = modo ? {H_MAX, 8'h59, 8'h59} : 24'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hora_out    <= 8'h00;
      minuto_out  <= 8'h00;
      segundo_out <= 8'h00;
      fin         <= 1'b0;
      activo      <= 1'b0;
      state       <= IDLE;
    end else if (cargar) begin
      hora_out    <= validar(hora_in, H_MAX);
      minuto_out  <= validar(minuto_in, 8'h59);
      segundo_out <= validar(segundo_in, 8'h59);
      fin         <= 1'b0;
      activo      <= 1'b0;
      state       <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (habilitar) begin
            state  <= RUN;
            activo <= 1'b1;
          end
        end
        RUN: begin
          fin <= 1'b0;
          if (!habilitar) begin
            state  <= IDLE;
            activo <= 1'b0;
          end else if (tick) begin
            if (vuelta && !WRAP) begin
              state  <= DONE;
              activo <= 1'b0;
              fin    <= 1'b1;
            end else begin
              {hora_out, minuto_out, segundo_out} <= sig;
              if (sig == term || vuelta) begin
                fin <= 1'b1;
                if (!WRAP) begin
                  state  <= DONE;
                  activo <= 1'b0;
                end
              end
            end
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temporizador_bcd.sv
// tb_temporizador_bcd: vector table, directed corners and
// random traffic against a seconds-count reference model.
module tb_temporizador_bcd;

  localparam int NT = 24 * 3600;

  logic clk = 1'b0;
  logic reset, tick, cargar, habilitar, modo;
  logic [7:0] h_in, m_in, s_in;
  logic [7:0] h0, m0, s0, h1, m1, s1;
  logic f0, a0, f1, a1;
  logic [25:0] o0, o1;

  int errors = 0;
  int checks = 0;

  int mst [2];
  int mt  [2];
  bit mf  [2];
  bit ma  [2];

  always #5 clk = ~clk;

  temporizador_bcd #(.HORA_MAX(23), .WRAP(1'b0)) d0 (
    .clk(clk), .reset(reset), .tick(tick),
    .cargar(cargar), .habilitar(habilitar), .modo(modo),
    .hora_in(h_in), .minuto_in(m_in), .segundo_in(s_in),
    .hora_out(h0), .minuto_out(m0), .segundo_out(s0),
    .fin(f0), .activo(a0)
  );

  temporizador_bcd #(.HORA_MAX(23), .WRAP(1'b1)) d1 (
    .clk(clk), .reset(reset), .tick(tick),
    .cargar(cargar), .habilitar(habilitar), .modo(modo),
    .hora_in(h_in), .minuto_in(m_in), .segundo_in(s_in),
    .hora_out(h1), .minuto_out(m1), .segundo_out(s1),
    .fin(f1), .activo(a1)
  );

  assign o0 = {h0, m0, s0, f0, a0};
  assign o1 = {h1, m1, s1, f1, a1};

  typedef struct {
    logic        c, hb, t, md;
    logic [7:0]  hi, mi, si;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [25:0] act,
                     input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got hms/fin/act=%h required %h",
               nm, act, exp);
    end
  endtask

  function automatic int val(input logic [7:0] v, input int mx);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return mx;
    if (hi * 10 + lo > mx) return mx;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [25:0] expv(input int w);
    return {bcd(mt[w] / 3600), bcd((mt[w] / 60) % 60),
            bcd(mt[w] % 60), mf[w], ma[w]};
  endfunction

  task automatic mdl_reset();
    for (int w = 0; w < 2; w++) begin
      mst[w] = 0; mt[w] = 0; mf[w] = 0; ma[w] = 0;
    end
  endtask

  // States: 0 idle, 1 run, 2 done. w is also the WRAP value.
  task automatic mdl_update(input int w);
    int tr;
    bit was;
    tr = modo ? NT - 1 : 0;
    if (cargar) begin
      mt[w] = val(h_in, 23) * 3600 + val(m_in, 59) * 60
            + val(s_in, 59);
      mst[w] = 0; mf[w] = 0; ma[w] = 0;
    end else if (mst[w] == 0) begin
      if (habilitar) begin mst[w] = 1; ma[w] = 1; end
    end else if (mst[w] == 1) begin
      mf[w] = 0;
      if (!habilitar) begin
        mst[w] = 0; ma[w] = 0;
      end else if (tick) begin
        was = (mt[w] == tr);
        if (was && w == 0) begin
          mst[w] = 2; ma[w] = 0; mf[w] = 1;
        end else begin
          mt[w] = modo ? (mt[w] + 1) % NT : (mt[w] + NT - 1) % NT;
          if (mt[w] == tr || was) begin
            mf[w] = 1;
            if (w == 0) begin mst[w] = 2; ma[w] = 0; end
          end
        end
      end
    end
  endtask

  task automatic drv(input logic c, hb, t, md,
                     input logic [7:0] hi, mi, si);
    cargar = c; habilitar = hb; tick = t; modo = md;
    h_in = hi; m_in = mi; s_in = si;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    mdl_update(0);
    mdl_update(1);
    #1;
    chk("model_wrap0", o0, expv(0));
    chk("model_wrap1", o1, expv(1));
  endtask

  task automatic async_reset(input string nm);
    reset = 1'b1;
    #1;
    mdl_reset();
    chk({nm, "_d0"}, o0, 26'h0);
    chk({nm, "_d1"}, o1, 26'h0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0, 8'h00,8'h01,8'h00, {24'h000100,2'b00}};
    tbl[1]  = '{0,1,1,0, 8'h00,8'h00,8'h00, {24'h000100,2'b01}};
    tbl[2]  = '{0,1,1,0, 8'h00,8'h00,8'h00, {24'h000059,2'b01}};
    tbl[3]  = '{0,1,0,0, 8'h00,8'h00,8'h00, {24'h000059,2'b01}};
    tbl[4]  = '{1,1,0,0, 8'h2F,8'h75,8'h3A, {24'h235959,2'b00}};
    tbl[5]  = '{1,0,0,0, 8'h10,8'h6A,8'h05, {24'h105905,2'b00}};
    tbl[6]  = '{1,0,0,0, 8'h25,8'h00,8'h00, {24'h230000,2'b00}};
    tbl[7]  = '{1,0,0,0, 8'h00,8'h00,8'h01, {24'h000001,2'b00}};
    tbl[8]  = '{0,1,0,0, 8'h00,8'h00,8'h00, {24'h000001,2'b01}};
    tbl[9]  = '{0,1,1,0, 8'h00,8'h00,8'h00, {24'h000000,2'b10}};
    tbl[10] = '{0,1,1,0, 8'h00,8'h00,8'h00, {24'h000000,2'b10}};
    tbl[11] = '{1,1,1,0, 8'h12,8'h34,8'h56, {24'h123456,2'b00}};

    drv(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    mdl_reset();
    #12;
    chk("reset_d0", o0, 26'h0);
    chk("reset_d1", o1, 26'h0);
    reset = 1'b0;
    #4;

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].c, tbl[i].hb, tbl[i].t, tbl[i].md,
          tbl[i].hi, tbl[i].mi, tbl[i].si);
      step_cycle();
      chk($sformatf("vec%0d", i), o0, tbl[i].exp);
    end

    // Count down a full minute into DONE.
    async_reset("rst_a");
    drv(1, 0, 0, 0, 8'h00, 8'h01, 8'h00); step_cycle();
    drv(0, 1, 0, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    drv(0, 1, 1, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    chk("down_first", o0, {24'h000059, 2'b01});
    for (int i = 0; i < 59; i++) step_cycle();
    chk("down_done", o0, {24'h000000, 2'b10});

    // Up count wrap with a one-cycle fin pulse.
    drv(1, 0, 0, 1, 8'h23, 8'h59, 8'h59); step_cycle();
    drv(0, 1, 0, 1, 8'h00, 8'h00, 8'h00); step_cycle();
    drv(0, 1, 1, 1, 8'h00, 8'h00, 8'h00); step_cycle();
    chk("wrap_pulse", o1, {24'h000000, 2'b11});
    chk("stop_at_term", o0, {24'h235959, 2'b10});
    drv(0, 1, 0, 1, 8'h00, 8'h00, 8'h00); step_cycle();
    chk("wrap_fin_drop", o1, {24'h000000, 2'b01});
    drv(0, 1, 1, 1, 8'h00, 8'h00, 8'h00); step_cycle();
    chk("wrap_next", o1, {24'h000001, 2'b01});

    // Pause keeps the count.
    drv(1, 0, 0, 0, 8'h00, 8'h10, 8'h00); step_cycle();
    drv(0, 1, 0, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 1, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    end
    chk("pause_hold", o0, {24'h001000, 2'b00});
    drv(0, 1, 0, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    drv(0, 1, 1, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    chk("pause_resume", o0, {24'h000959, 2'b01});

    // Load beats a same-cycle tick.
    drv(1, 0, 0, 0, 8'h01, 8'h00, 8'h00); step_cycle();
    drv(0, 1, 0, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    drv(1, 1, 1, 0, 8'h12, 8'h34, 8'h56); step_cycle();
    chk("load_vs_tick", o0, {24'h123456, 2'b00});

    // Asynchronous reset mid-run and out of DONE.
    drv(1, 0, 0, 0, 8'h05, 8'h05, 8'h05); step_cycle();
    drv(0, 1, 1, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    async_reset("rst_run");
    drv(1, 0, 0, 0, 8'h00, 8'h00, 8'h01); step_cycle();
    drv(0, 1, 0, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    drv(0, 1, 1, 0, 8'h00, 8'h00, 8'h00); step_cycle();
    chk("done_before_rst", o0, {24'h000000, 2'b10});
    async_reset("rst_done");

    // Random traffic, loads biased toward the terminals.
    modo = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int r;
      cargar    = ($urandom % 16 == 0);
      habilitar = ($urandom % 8 != 0);
      tick      = $urandom % 2;
      if ($urandom % 32 == 0) modo = ~modo;
      r = $urandom % 3;
      if (r == 0) begin
        h_in = 8'($urandom); m_in = 8'($urandom);
        s_in = 8'($urandom);
      end else if (r == 1) begin
        h_in = 8'h00; m_in = 8'h00;
        s_in = bcd($urandom_range(0, 4));
      end else begin
        h_in = 8'h23; m_in = 8'h59;
        s_in = bcd($urandom_range(55, 59));
      end
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
